// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer. It drives one external 16-bit CLA
// with one slice per cycle, LSB first, and chains the carry through a register.
module cla_mp_sequencer #(
    parameter int WORDS = 4,
    parameter int SW    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sub,
    input  logic                in_cin,
    input  logic [16*WORDS-1:0] in_a,
    input  logic [16*WORDS-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf,
    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    output logic                add_cin,
    input  logic [15:0]         add_s,
    input  logic                add_cout
);
    localparam int W = 16 * WORDS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    // Slice 0 goes straight to the adder registers, so only the upper slices are kept.
    logic [W-17:0] a_q, a_d, b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d, ovf_q, ovf_d;
    logic [15:0]   add_a_q, add_a_d, add_b_q, add_b_d;
    logic          carry_q, carry_d;
    logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [W-1:0]  b_eff;

    assign b_eff = in_sub ? ~in_b : in_b;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a[W-1:16];
                    b_d     = b_eff[W-1:16];
                    add_a_d = in_a[15:0];
                    add_b_d = b_eff[15:0];
                    carry_d = in_sub | in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++)
                    if (idx_q == SW'(i)) sum_d[16*i +: 16] = add_s;
                for (int i = 1; i < WORDS; i++)
                    if (idx_q == SW'(i-1)) begin
                        add_a_d = a_q[16*(i-1) +: 16];
                        add_b_d = b_q[16*(i-1) +: 16];
                    end
                idx_d = idx_q + SW'(1);
                if (idx_q == SW'(WORDS-1)) begin
                    // Adder inputs still hold the MSB slice, so their bit 15 are the operand signs.
                    cout_d  = add_cout;
                    ovf_d   = (add_a_q[15] == add_b_q[15]) && (add_s[15] != add_a_q[15]);
                    state_d = DONE;
                end else begin
                    carry_d = add_cout;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = carry_q;
endmodule
